tx_stream_scheduler: RTL and testbench
======================================

Name: tx_stream_scheduler

Overview:
Packet-granular round-robin scheduler. It merges NUM_PORTS application AXI-Stream TX sources (512-bit) into the single app2net_tx input of the network arbiter.
- A grant is held from a packet's first beat through its tlast beat, so packets are never interleaved.
- New grants are blocked while the remote-stall flag (pause) is high or a port is disabled.
- Per-port packet counters and a grant status output support debug and verification.

Parameters:
NUM_PORTS, 4, number of source ports (2..8).
IDX_W, 2, grant index width; must equal clog2(NUM_PORTS).
CNT_W, 32, width of each per-port packet counter.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous, active-low reset.
s_tdata  in  NUM_PORTS*512  source data, port i at [512*i +: 512].
s_tkeep  in  NUM_PORTS*64  source keep.
s_tdest  in  NUM_PORTS*16  source destination node id.
s_tlast  in  NUM_PORTS  source last.
s_tvalid  in  NUM_PORTS  source valid.
s_tready  out  NUM_PORTS  source ready.
m_tdata  out  512  merged data to app2net_tx.
m_tkeep  out  64  merged keep.
m_tdest  out  16  merged dest.
m_tlast  out  1  merged last.
m_tvalid  out  1  merged valid.
m_tready  in  1  merged ready.
port_en  in  NUM_PORTS  per-port enable; only sampled at arbitration.
pause  in  1  remote stall; blocks new grants only.
grant_idx  out  IDX_W  currently or last granted port.
busy  out  1  high in PKT state.
pkt_cnt  out  NUM_PORTS*CNT_W  completed packets per port.

Behaviour:
Reset values:
- State IDLE, rr_ptr = NUM_PORTS-1, grant_idx = 0, busy = 0.
- m_tvalid = 0, s_tready = 0, all pkt_cnt = 0.

States: IDLE, PKT.

IDLE:
- eligible = s_tvalid & port_en.
- If pause = 0 and eligible != 0: choose the first eligible index after rr_ptr, circular (rr_ptr+1 ... rr_ptr wrapped mod NUM_PORTS).
- Register that index into grant_idx and go to PKT. This costs 1 arbitration cycle; no beat transfers in IDLE.
- If pause = 1, or no port is eligible, stay in IDLE.

PKT datapath:
- Combinational mux: m_* = port[grant_idx] signals.
- m_tvalid = s_tvalid[grant_idx].
- s_tready[grant_idx] = m_tready; every other s_tready = 0.
- Latency through the block: 0 cycles.

PKT exit:
- On a transfer beat (m_tvalid & m_tready & m_tlast): increment pkt_cnt[grant_idx] (wraps at 2^CNT_W), set rr_ptr <= grant_idx, go to IDLE.
- The next grant is therefore made no earlier than the following cycle, which gives a 1-cycle bubble between packets.

PKT ignores pause and port_en. The packet in flight always completes, matching the arbiter's finished_packet semantics.

Boundary conditions:
- Source drops tvalid mid-packet: stay in PKT with m_tvalid = 0; the grant is not released.
- Single eligible port: it is regranted every packet.
- pause rising in the same cycle as a tlast beat: that beat completes, then the block holds in IDLE.
- port_en deasserted for the granted port mid-packet: no effect until tlast.
- Reset mid-packet: return to IDLE immediately. A partial packet upstream is the source's responsibility; no flush is done.
- Single-beat packet (tlast on the first beat): one IDLE cycle plus one PKT cycle.
- All s_tready are 0 in IDLE. This is mandatory so that no beat is accepted without a grant.

Decomposition:
- Shared package: AXIS widths DATA_W = 512, KEEP_W = 64, DEST_W = 16, plus the state encoding.
- One natural sub-module, rr_pick: a combinational rotate-priority encoder with inputs (req, ptr) and outputs (found, idx). It is reusable by a future RX dispatcher.

Test Plan:
1. Ports 0..3 each hold one 3-beat packet, all enabled, pause = 0 -> output order 0,1,2,3; pkt_cnt = 1 each; beats never interleave; 1 idle cycle between packets.
2. Port 1 streams continuously and port 2 sends one packet arriving during port 1's packet -> after port 1's tlast the grant goes to 2, then back to 1.
3. pause = 1 asserted on beat 2 of a 4-beat packet from port 0 -> all 4 beats complete; no new grant while pause = 1; the grant resumes the cycle after pause falls.
4. m_tready toggled 1,0,1,0 during a packet -> data held stable while stalled; s_tready of non-granted ports stays 0; no beat lost or duplicated.
5. port_en = 4'b1010 with all ports valid -> only ports 1 and 3 are granted, alternating.
6. aresetn low for 1 cycle mid-packet on port 2 -> m_tvalid = 0 and pkt_cnt = 0 on the next cycle; the first grant after reset goes to port 0.

Source files
------------

// File: rtl/tx_stream_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// tx_stream_scheduler_pkg
// Shared definitions for the TX stream scheduler slice: the AXI-Stream field
// widths used toward app2net_tx and the scheduler state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package tx_stream_scheduler_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int DEST_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/tx_stream_scheduler_if.sv
// ----------------------------------------------------------------------------
// tx_stream_scheduler_if
// AXI-Stream bundle carrying N lanes packed side by side (lane i occupies
// [W*i +: W] of each field). N = NUM_PORTS for the source side and N = 1 for
// the merged output.
// Signals: tdata, tkeep, tdest, tlast, tvalid (producer -> consumer),
//          tready (consumer -> producer).
// Modports: master = producer, slave = consumer.
// ----------------------------------------------------------------------------
interface tx_stream_scheduler_if #(
    parameter int N = 1
);
    import tx_stream_scheduler_pkg::*;

    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N*DEST_W-1:0] tdest;
    logic [N-1:0]        tlast;
    logic [N-1:0]        tvalid;
    logic [N-1:0]        tready;

    modport master (
        output tdata, tkeep, tdest, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tdest, tlast, tvalid,
        output tready
    );

endinterface

// File: rtl/tx_stream_scheduler_rr_pick.sv
// ----------------------------------------------------------------------------
// tx_stream_scheduler_rr_pick
// Combinational rotate-priority encoder. Returns the first requesting index
// strictly after ptr_i, searching circularly (ptr_i+1 ... ptr_i, mod N).
// Ports:
//   req_i   [N]      request vector
//   ptr_i   [IDX_W]  last served index (search starts just after it)
//   found_o          at least one request present
//   idx_o   [IDX_W]  chosen index (0 when found_o is low)
// ----------------------------------------------------------------------------
module tx_stream_scheduler_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down to the nearest so that the closest
    // requester after ptr_i is the last (and therefore winning) assignment.
    // The modulo is done in int so non-power-of-two N wraps correctly.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/tx_stream_scheduler.sv
// ----------------------------------------------------------------------------
// tx_stream_scheduler
// Packet-granular round-robin merge of NUM_PORTS AXI-Stream TX sources into the
// single app2net_tx stream. A grant is held from first beat through tlast, so
// packets never interleave. New grants are blocked while pause_i is high;
// port_en_i masks sources at arbitration time only.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   s_axis          NUM_PORTS source lanes (slave side)
//   m_axis          merged output lane (master side), zero-latency mux
//   port_en_i       per-port enable, sampled only in IDLE
//   pause_i         remote stall, blocks new grants only
//   grant_idx_o     current / last granted port
//   busy_o          high while a packet grant is held
//   pkt_cnt_o       completed packets per port, port i at [CNT_W*i +: CNT_W]
// ----------------------------------------------------------------------------
module tx_stream_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2,
    parameter int CNT_W     = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    tx_stream_scheduler_if.slave       s_axis,
    tx_stream_scheduler_if.master      m_axis,
    input  logic [NUM_PORTS-1:0]       port_en_i,
    input  logic                       pause_i,
    output logic [IDX_W-1:0]           grant_idx_o,
    output logic                       busy_o,
    output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt_o
);
    import tx_stream_scheduler_pkg::*;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] cnt_d [NUM_PORTS];

    logic [DATA_W-1:0] port_data [NUM_PORTS];
    logic [KEEP_W-1:0] port_keep [NUM_PORTS];
    logic [DEST_W-1:0] port_dest [NUM_PORTS];

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             last_beat;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign port_data[i] = s_axis.tdata[DATA_W*i +: DATA_W];
        assign port_keep[i] = s_axis.tkeep[KEEP_W*i +: KEEP_W];
        assign port_dest[i] = s_axis.tdest[DEST_W*i +: DEST_W];
        assign pkt_cnt_o[CNT_W*i +: CNT_W] = cnt_q[i];
    end

    tx_stream_scheduler_rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (s_axis.tvalid & port_en_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Output mux is purely combinational. Outside PKT nothing may handshake,
    // so tvalid and every tready are forced low there.
    always_comb begin
        m_axis.tdata  = port_data[grant_q];
        m_axis.tkeep  = port_keep[grant_q];
        m_axis.tdest  = port_dest[grant_q];
        m_axis.tlast  = s_axis.tlast[grant_q];
        m_axis.tvalid = 1'b0;
        s_axis.tready = '0;
        if (state_q == ST_PKT) begin
            m_axis.tvalid          = s_axis.tvalid[grant_q];
            s_axis.tready[grant_q] = m_axis.tready;
        end
    end

    assign last_beat = m_axis.tvalid & m_axis.tready & m_axis.tlast;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!pause_i && pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                // pause_i and port_en_i are ignored here: the packet in
                // flight always runs to its tlast.
                if (last_beat) begin
                    cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
                    rr_ptr_d       = grant_q;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rr_ptr resets to the last port so the first grant after reset is port 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= IDX_W'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q == ST_PKT);

endmodule

// File: tb/tb_tx_stream_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tx_stream_scheduler
// Directed bench for tx_stream_scheduler with four sources. Each source is a
// small packet generator (packets remaining, packet length, current beat);
// beat data encodes {port, beat} so the merged stream can be decoded and
// checked for order, interleaving, lost or duplicated beats and stall hold.
// ----------------------------------------------------------------------------
module tb_tx_stream_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  portEn = 4'hf;
    logic        pause = 1'b0;
    logic [1:0]  grantIdx;
    logic        busy;
    logic [127:0] pktCnt;

    tx_stream_scheduler_if #(.N(4)) s_axis ();
    tx_stream_scheduler_if #(.N(1)) m_axis ();

    tx_stream_scheduler #(
        .NUM_PORTS (4),
        .IDX_W     (2),
        .CNT_W     (32)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axis      (s_axis),
        .m_axis      (m_axis),
        .port_en_i   (portEn),
        .pause_i     (pause),
        .grant_idx_o (grantIdx),
        .busy_o      (busy),
        .pkt_cnt_o   (pktCnt)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    int remain [4];
    int len [4];
    int beatNo [4];
    int monBeat [4];
    int orderQ [$];

    int curPort = -1;
    int lastLastCycle = -1;
    int gapMin = 1000;
    int gapMax = -1;
    int seqErr = 0;
    int dataErr = 0;
    int interleaveErr = 0;
    int holdErr = 0;
    int readyErr = 0;
    logic prevStall = 1'b0;
    logic [511:0] prevData = '0;

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int cnt(input int p);
        return int'(pktCnt[p*32 +: 32]);
    endfunction

    function automatic int orderAt(input int i);
        if (i < orderQ.size()) return orderQ[i];
        return -1;
    endfunction

    task automatic driveSources();
        logic [15:0] w;
        for (int p = 0; p < 4; p++) begin
            w = {8'(p), 8'(beatNo[p])};
            s_axis.tvalid[p]            = (remain[p] > 0);
            s_axis.tlast[p]             = (beatNo[p] == len[p] - 1);
            s_axis.tdata[p*512 +: 512]  = {32{w}};
            s_axis.tkeep[p*64 +: 64]    = {8{8'(p + 1)}};
            s_axis.tdest[p*16 +: 16]    = 16'(p);
        end
    endtask

    task automatic setPacket(input int p, input int n, input int l);
        remain[p] = n;
        len[p]    = l;
        driveSources();
    endtask

    task automatic clearStats();
        orderQ.delete();
        gapMin = 1000;
        gapMax = -1;
        lastLastCycle = -1;
    endtask

    // Sampled at the falling edge: handshake rules and the merged beat log.
    task automatic monitorSample();
        logic [3:0] expReady;
        logic [15:0] w;
        int p;
        int b;
        expReady = busy ? (4'(m_axis.tready) << grantIdx) : 4'b0000;
        if (s_axis.tready !== expReady) readyErr++;
        if (prevStall && (!m_axis.tvalid || m_axis.tdata !== prevData)) holdErr++;
        prevStall = m_axis.tvalid && !m_axis.tready;
        prevData  = m_axis.tdata;
        if (m_axis.tvalid && m_axis.tready) begin
            p = int'(m_axis.tdest);
            b = int'(m_axis.tdata[7:0]);
            if (p > 3) begin
                dataErr++;
            end else begin
                w = {8'(p), 8'(b)};
                if (m_axis.tdata !== {32{w}} || m_axis.tkeep !== {8{8'(p + 1)}}) dataErr++;
                if (curPort < 0) begin
                    if (lastLastCycle >= 0) begin
                        if (cycle - lastLastCycle < gapMin) gapMin = cycle - lastLastCycle;
                        if (cycle - lastLastCycle > gapMax) gapMax = cycle - lastLastCycle;
                    end
                    curPort = p;
                end else if (p != curPort) begin
                    interleaveErr++;
                end
                if (b != monBeat[p]) seqErr++;
                if (m_axis.tlast !== (b == len[p] - 1)) seqErr++;
                monBeat[p]++;
                if (m_axis.tlast) begin
                    orderQ.push_back(p);
                    curPort = -1;
                    monBeat[p] = 0;
                    lastLastCycle = cycle;
                end
            end
        end
    endtask

    // One clock: observe at negedge, then advance the source models after the
    // rising edge for every beat that was accepted.
    task automatic applyStimulus();
        logic [3:0] sFire;
        logic inReset;
        @(negedge aclk);
        inReset = !aresetn;
        sFire = s_axis.tvalid & s_axis.tready;
        if (!inReset) monitorSample();
        @(posedge aclk);
        #1;
        cycle++;
        for (int p = 0; p < 4; p++) begin
            if (inReset) begin
                beatNo[p]  = 0;
                monBeat[p] = 0;
            end else if (sFire[p]) begin
                if (beatNo[p] == len[p] - 1) begin
                    beatNo[p] = 0;
                    remain[p]--;
                end else begin
                    beatNo[p]++;
                end
            end
        end
        if (inReset) begin
            curPort = -1;
            prevStall = 1'b0;
        end
        driveSources();
        #1;
    endtask

    task automatic waitPackets(input string tag, input int n, input int budget);
        int i = 0;
        while (orderQ.size() < n && i < budget) begin
            applyStimulus();
            i++;
        end
        checkOutput({tag, "_done"}, 512'(orderQ.size() >= n), 512'(1));
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            remain[p] = 0;
            len[p] = 1;
            beatNo[p] = 0;
            monBeat[p] = 0;
        end
        m_axis.tready = 1'b1;
        driveSources();
        clearStats();

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_mvalid", m_axis.tvalid, 1'b0);
        checkOutput("rst_sready", s_axis.tready, 4'h0);
        checkOutput("rst_grant", grantIdx, 2'd0);
        checkOutput("rst_cnt", pktCnt, 128'h0);
        aresetn = 1'b1;

        // 1: four 3-beat packets, served 0,1,2,3 with one idle cycle between
        $display("[TB] test 1: round robin over all ports");
        clearStats();
        for (int p = 0; p < 4; p++) setPacket(p, 1, 3);
        waitPackets("t1", 4, 60);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_order%0d", i), orderAt(i), i);
            checkOutput($sformatf("t1_cnt%0d", i), cnt(i), 1);
        end
        checkOutput("t1_interleave", interleaveErr, 0);
        checkOutput("t1_gapmin", gapMin, 2);
        checkOutput("t1_gapmax", gapMax, 2);

        // 2: port 1 streams, port 2 arrives mid-packet -> 1,2,1,1
        $display("[TB] test 2: late arrival gets next grant");
        clearStats();
        setPacket(1, 3, 4);
        applyStimulus();
        applyStimulus();
        setPacket(2, 1, 2);
        waitPackets("t2", 4, 80);
        checkOutput("t2_order0", orderAt(0), 1);
        checkOutput("t2_order1", orderAt(1), 2);
        checkOutput("t2_order2", orderAt(2), 1);
        checkOutput("t2_order3", orderAt(3), 1);
        checkOutput("t2_cnt1", cnt(1), 4);
        checkOutput("t2_cnt2", cnt(2), 2);

        // 3: pause rises on beat 2 of a 4-beat packet from port 0
        $display("[TB] test 3: pause blocks new grants only");
        clearStats();
        setPacket(0, 1, 4);
        applyStimulus();
        checkOutput("t3_busy", busy, 1'b1);
        checkOutput("t3_grant0", grantIdx, 2'd0);
        applyStimulus();
        setPacket(3, 1, 2);
        pause = 1'b1;
        waitPackets("t3a", 1, 20);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("t3_order0", orderAt(0), 0);
        checkOutput("t3_cnt0", cnt(0), 2);
        checkOutput("t3_hold_busy", busy, 1'b0);
        checkOutput("t3_hold_mvalid", m_axis.tvalid, 1'b0);
        checkOutput("t3_hold_cnt3", cnt(3), 1);
        pause = 1'b0;
        applyStimulus();
        checkOutput("t3_resume_busy", busy, 1'b1);
        checkOutput("t3_resume_grant", grantIdx, 2'd3);
        waitPackets("t3b", 2, 20);
        checkOutput("t3_cnt3", cnt(3), 2);

        // 4: m_tready toggling during a packet
        $display("[TB] test 4: output backpressure");
        clearStats();
        setPacket(0, 1, 4);
        setPacket(2, 1, 1);
        for (int i = 0; i < 40 && orderQ.size() < 2; i++) begin
            m_axis.tready = ~m_axis.tready;
            applyStimulus();
        end
        m_axis.tready = 1'b1;
        checkOutput("t4_done", 512'(orderQ.size()), 512'(2));
        checkOutput("t4_order0", orderAt(0), 0);
        checkOutput("t4_order1", orderAt(1), 2);
        checkOutput("t4_hold", holdErr, 0);
        checkOutput("t4_cnt0", cnt(0), 3);
        checkOutput("t4_cnt2", cnt(2), 3);

        // 5: only ports 1 and 3 enabled, single-beat packets -> 3,1,3,1
        $display("[TB] test 5: port enable mask");
        clearStats();
        portEn = 4'b1010;
        setPacket(0, 1, 1);
        setPacket(1, 2, 1);
        setPacket(2, 1, 1);
        setPacket(3, 2, 1);
        waitPackets("t5", 4, 40);
        applyStimulus();
        applyStimulus();
        checkOutput("t5_order0", orderAt(0), 3);
        checkOutput("t5_order1", orderAt(1), 1);
        checkOutput("t5_order2", orderAt(2), 3);
        checkOutput("t5_order3", orderAt(3), 1);
        checkOutput("t5_count", 512'(orderQ.size()), 512'(4));
        checkOutput("t5_gapmin", gapMin, 2);
        checkOutput("t5_gapmax", gapMax, 2);
        checkOutput("t5_cnt", pktCnt, {32'd4, 32'd3, 32'd6, 32'd3});
        setPacket(0, 0, 1);
        setPacket(2, 0, 1);
        portEn = 4'hf;

        // 6: reset for one cycle in the middle of a port-2 packet
        $display("[TB] test 6: reset mid-packet");
        clearStats();
        setPacket(2, 1, 4);
        applyStimulus();
        applyStimulus();
        checkOutput("t6_pre_busy", busy, 1'b1);
        checkOutput("t6_pre_grant", grantIdx, 2'd2);
        aresetn = 1'b0;
        applyStimulus();
        checkOutput("t6_mvalid", m_axis.tvalid, 1'b0);
        checkOutput("t6_busy", busy, 1'b0);
        checkOutput("t6_sready", s_axis.tready, 4'h0);
        checkOutput("t6_cnt", pktCnt, 128'h0);
        aresetn = 1'b1;
        clearStats();
        setPacket(0, 1, 2);
        applyStimulus();
        checkOutput("t6_first_busy", busy, 1'b1);
        checkOutput("t6_first_grant", grantIdx, 2'd0);
        waitPackets("t6", 2, 30);
        checkOutput("t6_order0", orderAt(0), 0);
        checkOutput("t6_order1", orderAt(1), 2);
        checkOutput("t6_cnt0", cnt(0), 1);
        checkOutput("t6_cnt2", cnt(2), 1);

        // Accumulated stream checks over the whole run
        checkOutput("all_seq", seqErr, 0);
        checkOutput("all_data", dataErr, 0);
        checkOutput("all_interleave", interleaveErr, 0);
        checkOutput("all_hold", holdErr, 0);
        checkOutput("all_ready", readyErr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
